// File: rtl/conv_requant_pkg.sv
// Shared helpers for requantization stages: shift derivation, saturation bounds
// and the output buffer state encoding.
package conv_requant_pkg;

    // Encoding is {out_valid, skid_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } buf_state_t;

    function automatic int shift_amt(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/conv_output_requant_if.sv
// Stream bundle for the requant stage: accumulator beats in, requantized beats out.
interface conv_output_requant_if #(
    parameter int IN_W  = 28,
    parameter int OUT_W = 16,
    parameter int LANES = 2
);
    logic [LANES-1:0][IN_W-1:0]  data_in_0;
    logic                        data_in_0_valid;
    logic                        data_in_0_ready;
    logic [LANES-1:0][OUT_W-1:0] data_out_0;
    logic                        data_out_0_valid;
    logic                        data_out_0_ready;
    logic                        data_out_0_last;

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last
    );
endinterface

// File: rtl/fixed_round_sat.sv
// One lane of requantization: round-half-up rescale, signed saturation, optional ReLU.
module fixed_round_sat
    import conv_requant_pkg::*;
#(
    parameter int IN_W     = 28,
    parameter int IN_FRAC  = 7,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 3,
    parameter int HAS_RELU = 0
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] result
);
    localparam int SHIFT = shift_amt(IN_FRAC, OUT_FRAC);
    localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int WW    = IN_W + 1 + LSH;
    localparam logic signed [63:0] MAX_V = sat_max(OUT_W);
    localparam logic signed [63:0] MIN_V = sat_min(OUT_W);

    logic signed [WW-1:0] scaled;
    logic signed [63:0]   wide;

    // One extra bit of headroom so the rounding offset can never wrap
    if (SHIFT > 0) begin : g_round
        localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (SHIFT - 1);
        logic signed [IN_W:0] sum;
        assign sum    = $signed({value[IN_W-1], value}) + HALF;
        assign scaled = sum >>> SHIFT;
    end else if (SHIFT == 0) begin : g_pass
        assign scaled = $signed({value[IN_W-1], value});
    end else begin : g_left
        assign scaled = $signed({value[IN_W-1], value, {LSH{1'b0}}});
    end

    always_comb begin
        wide = 64'(scaled);
        if (wide > MAX_V) begin
            result = MAX_V[OUT_W-1:0];
        end else if (wide < MIN_V) begin
            result = MIN_V[OUT_W-1:0];
        end else begin
            result = wide[OUT_W-1:0];
        end
        if (HAS_RELU != 0 && result[OUT_W-1]) begin
            result = '0;
        end
    end
endmodule

// File: rtl/conv_output_requant.sv
// Convolution output stage: per-lane requant, pixel beat counter and a
// registered-ready skid buffer toward the downstream consumer.
module conv_output_requant
    import conv_requant_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0    = 28,
    parameter int DATA_IN_0_PRECISION_1    = 7,
    parameter int DATA_OUT_0_PRECISION_0   = 16,
    parameter int DATA_OUT_0_PRECISION_1   = 3,
    parameter int OUT_CHANNELS_PARALLELISM = 2,
    parameter int OUT_CHANNELS_DEPTH       = 2,
    parameter int HAS_RELU                 = 0
) (
    input logic clk,
    input logic rst,
    conv_output_requant_if.slave bus
);
    localparam int LANES = OUT_CHANNELS_PARALLELISM;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int CNT_W = (OUT_CHANNELS_DEPTH > 1) ? $clog2(OUT_CHANNELS_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUT_CHANNELS_DEPTH - 1);

    buf_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic in_ready, in_hs, out_hs, in_last;
    logic load_out, load_skid, skid_to_out;
    logic [LANES-1:0][OUT_W-1:0] lane_q, out_data, skid_data;
    logic out_last, skid_last;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fixed_round_sat #(
            .IN_W    (DATA_IN_0_PRECISION_0),
            .IN_FRAC (DATA_IN_0_PRECISION_1),
            .OUT_W   (OUT_W),
            .OUT_FRAC(DATA_OUT_0_PRECISION_1),
            .HAS_RELU(HAS_RELU)
        ) u_lane (
            .value (bus.data_in_0[i]),
            .result(lane_q[i])
        );
    end

    assign in_hs   = bus.data_in_0_valid & in_ready;
    assign out_hs  = (state != EMPTY) & bus.data_out_0_ready;
    assign in_last = (cnt == CNT_MAX);

    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    load_out   = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (out_hs && in_hs) begin
                    load_out = 1'b1;
                end else if (out_hs) begin
                    state_next = EMPTY;
                end else if (in_hs) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_hs) begin
                    skid_to_out = 1'b1;
                    state_next  = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Ready is registered from the next state so it never sees data_out_0_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != FULL);
            if (in_hs) begin
                cnt <= in_last ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else begin
            if (load_out) begin
                out_data <= lane_q;
                out_last <= in_last;
            end else if (skid_to_out) begin
                out_data <= skid_data;
                out_last <= skid_last;
            end
            if (load_skid) begin
                skid_data <= lane_q;
                skid_last <= in_last;
            end
        end
    end

    assign bus.data_in_0_ready  = in_ready;
    assign bus.data_out_0_valid = (state != EMPTY);
    assign bus.data_out_0       = out_data;
    assign bus.data_out_0_last  = out_last;
endmodule

// File: tb/tb_conv_output_requant.sv
// Self-checking bench for conv_output_requant against a real-arithmetic reference.
module tb_conv_output_requant;
    localparam int IN_W  = 28;
    localparam int OUT_W = 16;
    localparam int LANES = 2;
    localparam int DEPTH = 2;

    typedef logic [LANES-1:0][IN_W-1:0]  in_t;
    typedef logic [LANES-1:0][OUT_W-1:0] out_t;
    typedef struct {
        in_t d;
        bit  last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests_run = 0;
    int failures  = 0;

    conv_output_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) bus ();
    conv_output_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) bus_r ();

    assign bus_r.data_in_0        = bus.data_in_0;
    assign bus_r.data_in_0_valid  = bus.data_in_0_valid;
    assign bus_r.data_out_0_ready = bus.data_out_0_ready;

    conv_output_requant #(.HAS_RELU(0)) dut (.clk(clk), .rst(rst), .bus(bus));
    conv_output_requant #(.HAS_RELU(1)) dut_relu (.clk(clk), .rst(rst), .bus(bus_r));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Output format has 3 fractional bits, accumulator 7: one output LSB is 16 input LSBs
    function automatic logic [OUT_W-1:0] ref_lane(input longint x, input bit relu);
        real r;
        longint v;
        longint hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        r = $floor(real'(x) / 16.0 + 0.5);
        v = longint'(r);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        if (relu && v < 0) v = 0;
        return OUT_W'(v);
    endfunction

    function automatic out_t exp_out(input in_t d, input bit relu);
        out_t o;
        for (int i = 0; i < LANES; i++) begin
            o[i] = ref_lane(longint'($signed(d[i])), relu);
        end
        return o;
    endfunction

    function automatic in_t pack(input longint a, input longint b);
        in_t p;
        p[0] = IN_W'(a);
        p[1] = IN_W'(b);
        return p;
    endfunction

    function automatic longint rand_lane();
        logic signed [IN_W-1:0] t;
        case ($urandom_range(0, 3))
            0: begin
                t = IN_W'($urandom);
                return longint'(t);
            end
            1: return longint'($urandom_range(0, 64)) - 32;
            default: return longint'($urandom_range(0, 1200000)) - 600000;
        endcase
    endfunction

    function automatic in_t rand_beat();
        return pack(rand_lane(), rand_lane());
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b1;
        bus.data_in_0        = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        apply_reset();
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0 = pack(160, -160);
        cycle();
        bus.data_in_0 = pack(320, 48);
        cycle();
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b0;
        cycle();
        tests_run++;
        if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0_last !== 1'b1 || bus.data_out_0 !== exp_out(pack(320, 48), 0)) begin
            failures++;
            $display("FAIL reset_pre: valid=%b last=%b data=%h, required 1 1 %h", bus.data_out_0_valid, bus.data_out_0_last, bus.data_out_0, exp_out(pack(320, 48), 0));
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.data_out_0_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b required 0", bus.data_out_0_valid);
        end
        tests_run++;
        if (bus.data_out_0_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_last: got %b required 0", bus.data_out_0_last);
        end
        tests_run++;
        if (bus.data_out_0 !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h required 0", bus.data_out_0);
        end
        tests_run++;
        if (bus.data_in_0_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b required 1", bus.data_in_0_ready);
        end
    endtask

    task automatic test_rounding();
        out_t want;
        apply_reset();
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0 = pack(24, -24);
        cycle();
        bus.data_in_0_valid = 1'b0;
        want[0] = 16'd2;
        want[1] = 16'hFFFF;
        tests_run++;
        if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0 !== want) begin
            failures++;
            $display("FAIL round_half: valid=%b data=%h, required 1 %h", bus.data_out_0_valid, bus.data_out_0, want);
        end
        want[1] = 16'd0;
        tests_run++;
        if (bus_r.data_out_0 !== want) begin
            failures++;
            $display("FAIL round_relu: got %h required %h", bus_r.data_out_0, want);
        end
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0 = pack(8, 7);
        cycle();
        bus.data_in_0_valid = 1'b0;
        want[0] = 16'd1;
        want[1] = 16'd0;
        tests_run++;
        if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0 !== want) begin
            failures++;
            $display("FAIL round_8_7: valid=%b data=%h, required 1 %h", bus.data_out_0_valid, bus.data_out_0, want);
        end
        cycle();
        tests_run++;
        if (bus.data_out_0_valid !== 1'b0) begin
            failures++;
            $display("FAIL round_drain: valid=%b required 0", bus.data_out_0_valid);
        end
    endtask

    task automatic test_saturation();
        in_t beats[3];
        out_t want;
        apply_reset();
        beats[0] = pack(longint'(1) << 20, -(longint'(1) << 22));
        beats[1] = pack(524279, -524296);
        beats[2] = pack(524280, -524297);
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0 = beats[0];
        cycle();
        want[0] = 16'd32767;
        want[1] = 16'h8000;
        tests_run++;
        if (bus.data_out_0 !== want) begin
            failures++;
            $display("FAIL sat_main: got %h required %h", bus.data_out_0, want);
        end
        want[1] = 16'd0;
        tests_run++;
        if (bus_r.data_out_0 !== want) begin
            failures++;
            $display("FAIL sat_relu: got %h required %h", bus_r.data_out_0, want);
        end
        for (int i = 1; i < 3; i++) begin
            bus.data_in_0 = beats[i];
            cycle();
            tests_run++;
            if (bus.data_out_0 !== exp_out(beats[i], 0) || bus_r.data_out_0 !== exp_out(beats[i], 1)) begin
                failures++;
                $display("FAIL sat_edge%0d: got %h/%h required %h/%h", i, bus.data_out_0, bus_r.data_out_0, exp_out(beats[i], 0), exp_out(beats[i], 1));
            end
        end
        bus.data_in_0_valid = 1'b0;
        cycle();
    endtask

    task automatic test_last_flag();
        in_t d;
        apply_reset();
        bus.data_in_0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = pack(16 * i + 1, -16 * i);
            bus.data_in_0 = d;
            cycle();
            tests_run++;
            if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0_last !== 1'(i % 2) || bus.data_out_0 !== exp_out(d, 0)) begin
                failures++;
                $display("FAIL last_beat%0d: valid=%b last=%b data=%h, required 1 %b %h", i, bus.data_out_0_valid, bus.data_out_0_last, bus.data_out_0, 1'(i % 2), exp_out(d, 0));
            end
        end
        bus.data_in_0_valid = 1'b0;
        cycle();
        tests_run++;
        if (bus.data_out_0_valid !== 1'b0) begin
            failures++;
            $display("FAIL last_drain: valid=%b required 0", bus.data_out_0_valid);
        end
    endtask

    task automatic test_backpressure();
        in_t beats[3];
        int idx;
        int got;
        bit in_hs;
        apply_reset();
        for (int i = 0; i < 3; i++) beats[i] = pack(16 * (i + 1) + 3, -16 * (i + 5));
        bus.data_out_0_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            bus.data_in_0_valid = (idx < 3);
            bus.data_in_0 = (idx < 3) ? beats[idx] : '0;
            in_hs = bus.data_in_0_valid && bus.data_in_0_ready;
            cycle();
            if (in_hs) idx++;
        end
        tests_run++;
        if (idx != 2 || bus.data_in_0_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept: accepted=%0d ready=%b, required 2 0", idx, bus.data_in_0_ready);
        end
        tests_run++;
        if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0 !== exp_out(beats[0], 0)) begin
            failures++;
            $display("FAIL bp_hold: valid=%b data=%h, required 1 %h", bus.data_out_0_valid, bus.data_out_0, exp_out(beats[0], 0));
        end
        bus.data_out_0_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            bus.data_in_0_valid = (idx < 3);
            bus.data_in_0 = (idx < 3) ? beats[idx] : '0;
            in_hs = bus.data_in_0_valid && bus.data_in_0_ready;
            if (bus.data_out_0_valid) begin
                tests_run++;
                if (got >= 3) begin
                    failures++;
                    $display("FAIL bp_extra: output %0d data=%h, required only 3 outputs", got, bus.data_out_0);
                end else if (bus.data_out_0 !== exp_out(beats[got], 0) || bus.data_out_0_last !== 1'(got % 2)) begin
                    failures++;
                    $display("FAIL bp_order%0d: data=%h last=%b, required %h %b", got, bus.data_out_0, bus.data_out_0_last, exp_out(beats[got], 0), 1'(got % 2));
                end
                got++;
            end
            cycle();
            if (in_hs) idx++;
        end
        tests_run++;
        if (got != 3 || idx != 3) begin
            failures++;
            $display("FAIL bp_count: outputs=%0d accepted=%0d, required 3 3", got, idx);
        end
        bus.data_in_0_valid = 1'b0;
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t e;
        in_t cur;
        out_t prev_data;
        bit prev_last;
        bit stall_prev;
        bit in_hs;
        int sent, recv, mcnt, guard;
        apply_reset();
        sent = 0;
        recv = 0;
        mcnt = 0;
        guard = 0;
        stall_prev = 0;
        prev_data = '0;
        prev_last = 0;
        cur = rand_beat();
        while ((sent < 1000 || q.size() > 0) && guard < 20000) begin
            bus.data_in_0_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
            bus.data_in_0        = cur;
            bus.data_out_0_ready = ($urandom_range(0, 9) < 7) || (sent >= 1000);
            if (stall_prev) begin
                tests_run++;
                if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0 !== prev_data || bus.data_out_0_last !== prev_last) begin
                    failures++;
                    $display("FAIL rnd_stable: valid=%b data=%h last=%b, required 1 %h %b", bus.data_out_0_valid, bus.data_out_0, bus.data_out_0_last, prev_data, prev_last);
                end
            end
            if (bus.data_out_0_valid && bus.data_out_0_ready) begin
                tests_run++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious: data=%h with no beat pending", bus.data_out_0);
                end else begin
                    e = q.pop_front();
                    if (bus.data_out_0 !== exp_out(e.d, 0) || bus_r.data_out_0 !== exp_out(e.d, 1) || bus.data_out_0_last !== e.last) begin
                        failures++;
                        $display("FAIL rnd_beat%0d: data=%h relu=%h last=%b, required %h %h %b", recv, bus.data_out_0, bus_r.data_out_0, bus.data_out_0_last, exp_out(e.d, 0), exp_out(e.d, 1), e.last);
                    end
                end
                recv++;
            end
            in_hs = bus.data_in_0_valid && bus.data_in_0_ready;
            if (in_hs) begin
                q.push_back('{cur, (mcnt == DEPTH - 1)});
                mcnt = (mcnt + 1) % DEPTH;
                sent++;
                cur = rand_beat();
            end
            stall_prev = bus.data_out_0_valid && !bus.data_out_0_ready;
            prev_data  = bus.data_out_0;
            prev_last  = bus.data_out_0_last;
            cycle();
            guard++;
        end
        tests_run++;
        if (guard >= 20000 || recv != 1000) begin
            failures++;
            $display("FAIL rnd_total: received=%0d cycles=%0d, required 1000 within 20000", recv, guard);
        end
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        in_t w;
        apply_reset();
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0 = pack(100, 200);
        cycle();
        bus.data_in_0_valid = 1'b0;
        cycle();
        bus.data_out_0_ready = 1'b0;
        bus.data_in_0_valid  = 1'b1;
        bus.data_in_0 = pack(300, 400);
        cycle();
        bus.data_in_0 = pack(500, 600);
        cycle();
        bus.data_in_0_valid = 1'b0;
        tests_run++;
        if (bus.data_in_0_ready !== 1'b0 || bus.data_out_0_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_full: ready=%b valid=%b, required 0 1", bus.data_in_0_ready, bus.data_out_0_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.data_out_0_valid !== 1'b0 || bus.data_out_0_last !== 1'b0 || bus.data_out_0 !== '0 || bus.data_in_0_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_async: valid=%b last=%b data=%h ready=%b, required 0 0 0 1", bus.data_out_0_valid, bus.data_out_0_last, bus.data_out_0, bus.data_in_0_ready);
        end
        cycle();
        rst = 1'b0;
        cycle();
        bus.data_out_0_ready = 1'b1;
        bus.data_in_0_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = pack(-37 - 16 * i, 1000 + i);
            bus.data_in_0 = w;
            cycle();
            tests_run++;
            if (bus.data_out_0_valid !== 1'b1 || bus.data_out_0_last !== 1'(i) || bus.data_out_0 !== exp_out(w, 0)) begin
                failures++;
                $display("FAIL mid_after%0d: valid=%b last=%b data=%h, required 1 %b %h", i, bus.data_out_0_valid, bus.data_out_0_last, bus.data_out_0, 1'(i), exp_out(w, 0));
            end
        end
        bus.data_in_0_valid = 1'b0;
        cycle();
    endtask

    initial begin
        bus.data_in_0        = '0;
        bus.data_in_0_valid  = 1'b0;
        bus.data_out_0_ready = 1'b1;
        test_reset();
        test_rounding();
        test_saturation();
        test_last_flag();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/conv_output_requant.md
# conv_output_requant

Output stage placed directly after `convolution_arith`. It takes the full-width accumulator results (`OUT_CHANNELS_PARALLELISM` lanes per beat), rounds and saturates each lane to the layer output format, and optionally applies ReLU. It registers the results behind a skid buffer so upstream sees a registered `ready`. It also counts beats across `OUT_CHANNELS_DEPTH` and flags the beat that completes one output pixel.

## Interface
Parameters:
- `DATA_IN_0_PRECISION_0`, 28, accumulator width (16+8+clog2(16) for default conv)
- `DATA_IN_0_PRECISION_1`, 7, accumulator fractional bits
- `DATA_OUT_0_PRECISION_0`, 16, output width
- `DATA_OUT_0_PRECISION_1`, 3, output fractional bits
- `OUT_CHANNELS_PARALLELISM`, 2, lanes per beat
- `OUT_CHANNELS_DEPTH`, 2, beats per output pixel
- `HAS_RELU`, 0, 1 = clamp negatives to zero after saturation

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; **asynchronous, active-high**
- `data_in_0`  in  `DATA_IN_0_PRECISION_0` x `OUT_CHANNELS_PARALLELISM`  signed accumulator lanes
- `data_in_0_valid`  in  1
- `data_in_0_ready`  out  1
- `data_out_0`  out  `DATA_OUT_0_PRECISION_0` x `OUT_CHANNELS_PARALLELISM`  requantized lanes
- `data_out_0_valid`  out  1
- `data_out_0_ready`  in  1
- `data_out_0_last`  out  1  high on the beat completing `OUT_CHANNELS_DEPTH` beats

## Operation
- Per lane, using `SHIFT = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1`:
  - `SHIFT > 0`: add `1 << (SHIFT-1)`, then arithmetic right shift by `SHIFT`. This is round-half-up, i.e. floor(x+0.5).
  - `SHIFT = 0`: pass the value through unchanged.
  - `SHIFT < 0`: left shift by `-SHIFT`.
  - The addition is done at `DATA_IN_0_PRECISION_0+1` bits so it cannot overflow.
- Saturate to the signed range [-2^(W-1), 2^(W-1)-1], where W = `DATA_OUT_0_PRECISION_0`.
- If `HAS_RELU=1`, negative results become 0.
- Beat counter `cnt` runs 0..`OUT_CHANNELS_DEPTH`-1.
  - It advances on each input handshake (`data_in_0_valid & data_in_0_ready`) and wraps to 0 after `OUT_CHANNELS_DEPTH`-1.
  - `last` for a beat = (`cnt == OUT_CHANNELS_DEPTH-1`). It is captured with the data and travels with it through the output register and skid register.
  - `OUT_CHANNELS_DEPTH=1`: every beat is last.
- Storage is a main output register plus one skid register, and the state is the pair (out_valid, skid_valid):
  - EMPTY (0,0): an input handshake loads the output register.
  - ONE (1,0):
    - Output handshake with no input: go to EMPTY.
    - Output handshake with simultaneous input: reload the output register, stay in ONE.
    - Input while the output is stalled: load the skid register, go to FULL.
  - FULL (1,1): `data_in_0_ready`=0. An output handshake moves skid into the output register and returns to ONE.
- `data_in_0_ready = !skid_valid`, driven from a register, with no combinational path from `data_out_0_ready`.
- Data and `last` are stable while `data_out_0_valid & !data_out_0_ready`.

## Timing
- Latency: an input accepted in cycle N appears on `data_out_0` in cycle N+1.
- Sustains 1 beat/cycle when `data_out_0_ready` is held high.
- Reset values, applied immediately on `rst` rising:
  - `data_out_0_valid`=0, `data_out_0_last`=0, `data_out_0`=0
  - skid_valid=0, so `data_in_0_ready`=1 after reset; `cnt`=0
- Reset mid-pixel discards any partially counted pixel and the buffered beats. The first beat after reset has `cnt`=0.
- Valid/ready follow the AXI-stream convention: valid must not depend on ready, and a beat transfers on valid & ready at the clock edge.

## Structure
- Shared package `conv_requant_pkg`: the `SHIFT` computation function and the saturation bound constants (max/min for a given width). The package is shared with other requant stages in the convolution path.
- Sub-module `fixed_round_sat`: a single lane that does round, saturate and optional ReLU, purely combinationally. It is instantiated per lane by a generate loop.
- The top level holds the counter, output register, skid register and handshake.

## Test plan
All scenarios use the default parameters, SHIFT=4, with `data_out_0_ready`=1 unless stated otherwise.
- Rounding: lane0=24 (1.5), lane1=-24 (-1.5) -> out lane0=2, lane1=-1. Inputs 8 -> 1 and 7 -> 0.
- Saturation: lane0=2^20 -> 32767; lane1=-2^22 -> -32768. With `HAS_RELU=1`, lane1 -> 0 and lane0 -> 32767.
- Last flag: 6 consecutive beats -> `data_out_0_last` pattern 0,1,0,1,0,1, with one output per cycle after 1 cycle of latency.
- Backpressure: hold `data_out_0_ready`=0 while sending 3 beats.
  - Required response: 2 beats are accepted, then `data_in_0_ready`=0.
  - After ready is released, the outputs emerge in order with correct `last`, and none are lost or duplicated.
- Random valid/ready over 1000 beats: the output stream equals the reference model (floor(x/16+0.5), saturated). Data is stable during stalls.
- Async reset asserted mid-transfer, with FULL state and `cnt`=1:
  - Outputs go to 0 and `data_in_0_ready`=1 without waiting for a clock edge.
  - The next accepted beat has `last`=0.
